// File: rtl/frame_word_packer.sv
// ---------------------------------------------------------------------------
// frame_word_packer
//
// Captures one frame of pixel bytes over a valid/ready handshake and packs
// them little-endian into host words (first byte of a word in the LSBs).
// Packed words are queued in a small registered FIFO and presented on a
// word-stream port. The final (possibly partial, zero-padded) word of a frame
// is tagged so word_last marks it, and frame_done pulses once it is taken.
//
// Ports:
//   clk, rst_n        system clock (rising edge), async active-low reset
//   start             begin a frame; only looked at in IDLE
//   pix_data/valid    pixel byte input, pix_ready = byte accepted this cycle
//   word_data/valid   packed word output, word_ready = downstream takes it
//   word_last         head word is the final word of the frame
//   frame_done        one-cycle pulse after the final word is taken
//   busy              any state other than IDLE
//   byte_count        bytes accepted in the current (or last) frame
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; byte_count holds the previous frame's total
// CAPTURE| accepting bytes while the FIFO has room
// DRAIN  | all bytes taken; waiting for the last-tagged word to be popped
// DONE   | frame_done pulse, back to IDLE next cycle
// ---------------------------------------------------------------------------
module frame_word_packer #(
    parameter int PIX_W          = 8,
    parameter int BYTES_PER_WORD = 4,
    parameter int FRAME_BYTES    = 30000,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [PIX_W-1:0]                    pix_data,
    input  logic                                pix_valid,
    output logic                                pix_ready,
    output logic [PIX_W*BYTES_PER_WORD-1:0]     word_data,
    output logic                                word_valid,
    input  logic                                word_ready,
    output logic                                word_last,
    output logic                                frame_done,
    output logic                                busy,
    output logic [$clog2(FRAME_BYTES+1)-1:0]    byte_count
);

    localparam int WORD_W = PIX_W * BYTES_PER_WORD;
    localparam int CNT_W  = $clog2(FRAME_BYTES + 1);
    localparam int LANE_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int FILL_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0]  LAST_BYTE_IDX = CNT_W'(FRAME_BYTES - 1);
    localparam logic [LANE_W-1:0] LAST_LANE     = LANE_W'(BYTES_PER_WORD - 1);
    localparam logic [FILL_W-1:0] FIFO_FULL_CNT = FILL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [WORD_W-1:0]   pack_q, pack_d;
    logic [CNT_W-1:0]    byte_count_q, byte_count_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;

    logic [WORD_W-1:0]   mem_data_q [FIFO_DEPTH];
    logic                mem_last_q [FIFO_DEPTH];

    logic                fifo_full;
    logic                fifo_empty;
    logic                accept;
    logic                final_byte;
    logic                push;
    logic                pop;
    logic                head_last;
    logic [WORD_W-1:0]   word_now;

    // ------------------------------------------------------------------
    // Handshakes and packing datapath
    // ------------------------------------------------------------------
    always_comb begin
        fifo_full  = (fill_q == FIFO_FULL_CNT);
        fifo_empty = (fill_q == '0);
        pix_ready  = (state_q == ST_CAPTURE) && !fifo_full;
        accept     = pix_valid && pix_ready;
        final_byte = (byte_count_q == LAST_BYTE_IDX);
        word_valid = !fifo_empty;
        pop        = word_valid && word_ready;
        head_last  = mem_last_q[rd_ptr_q];
        word_data  = mem_data_q[rd_ptr_q];
        word_last  = word_valid && head_last;
        frame_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE);
        byte_count = byte_count_q;

        // Upper lanes of pack_q are still zero, so a partial final word
        // comes out zero-padded without extra masking.
        word_now = pack_q;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (lane_q == LANE_W'(i)) begin
                word_now[i*PIX_W +: PIX_W] = pix_data;
            end
        end

        push = accept && ((lane_q == LAST_LANE) || final_byte);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        lane_d       = lane_q;
        pack_d       = pack_q;
        byte_count_d = byte_count_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_CAPTURE;
                    lane_d       = '0;
                    pack_d       = '0;
                    byte_count_d = '0;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    byte_count_d = byte_count_q + CNT_W'(1);
                    if (push) begin
                        lane_d = '0;
                        pack_d = '0;
                    end else begin
                        lane_d = lane_q + LANE_W'(1);
                        pack_d = word_now;
                    end
                    if (final_byte) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // The last-tagged word is always the newest entry, so its
                // pop also means the FIFO is empty again.
                if (pop && head_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers and occupancy; push while full cannot happen since
    // pix_ready is low when the FIFO is full.
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = push ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        fill_d   = fill_q;
        case ({push, pop})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            pack_q       <= '0;
            byte_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            pack_q       <= pack_d;
            byte_count_q <= byte_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fill_q       <= fill_d;
        end
    end

    // Storage needs no reset: entries are only visible while fill_q != 0.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data_q[wr_ptr_q] <= word_now;
            mem_last_q[wr_ptr_q] <= final_byte;
        end
    end

endmodule

// File: tb/tb_frame_word_packer.sv
module tb_frame_word_packer;

    localparam int PW    = 8;
    localparam int BPW   = 4;
    localparam int FB    = 10;
    localparam int DEPTH = 2;
    localparam int WW    = PW * BPW;
    localparam int NW    = (FB + BPW - 1) / BPW;
    localparam int CW    = $clog2(FB + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [PW-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready;
    logic [WW-1:0] word_data;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          word_last;
    logic          frame_done;
    logic          busy;
    logic [CW-1:0] byte_count;

    frame_word_packer #(
        .PIX_W          (PW),
        .BYTES_PER_WORD (BPW),
        .FRAME_BYTES    (FB),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pix_data   (pix_data),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_last  (word_last),
        .frame_done (frame_done),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    int cyc = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int last_pop_cyc = -1;
    int first_acc_cyc = -1;
    int first_pop_cyc = -1;
    logic acc_f;

    logic [PW-1:0] fr [FB];
    logic [WW-1:0] got_w [$];
    logic          got_l [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive on the falling edge, observe 1ns later, i.e.
    // the handshakes that the following rising edge will act on.
    task automatic tick(input logic v, input logic [PW-1:0] d, input logic wr, input logic st);
        @(negedge clk);
        pix_valid  = v;
        pix_data   = d;
        word_ready = wr;
        start      = st;
        #1;
        cyc++;
        acc_f = pix_valid && pix_ready;
        if (acc_f && first_acc_cyc < 0) first_acc_cyc = cyc;
        if (word_valid && word_ready) begin
            got_w.push_back(word_data);
            got_l.push_back(word_last);
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            if (word_last) last_pop_cyc = cyc;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    endtask

    // Reference packing: word w holds bytes w*BPW.. little-endian, zero past FB.
    function automatic logic [WW-1:0] exp_word(input int w);
        logic [WW-1:0] r;
        r = '0;
        for (int l = 0; l < BPW; l++) begin
            if (w * BPW + l < FB) r = r | (WW'(fr[w*BPW+l]) << (PW * l));
        end
        return r;
    endfunction

    task automatic run_frame(input bit gaps, input int hold, input bit noise, input string nm);
        int idx, extra, n, d0, post, nchk;
        logic v, wr, st;
        logic [PW-1:0] d;
        idx = 0; extra = 0; n = 0; post = -1;
        got_w.delete(); got_l.delete();
        d0 = done_cnt;
        first_acc_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
        tick(1'b0, '0, 1'b1, 1'b1);
        tick(1'b0, '0, 1'b1, 1'b0);
        chk({nm, "_cnt_clr"}, byte_count, 0);
        chk({nm, "_busy"}, busy, 1);
        while (n < 400) begin
            v  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            d  = (idx < FB) ? fr[idx] : 8'hEE;
            wr = (n < hold) ? 1'b0 : (gaps ? ($urandom_range(0, 2) != 0) : 1'b1);
            st = noise && (n % 3 == 1) && (done_cnt == d0);
            tick(v, d, wr, st);
            if (acc_f) begin
                if (idx < FB) idx++;
                else extra++;
            end
            if (hold > 0 && n == hold - 1) begin
                chk({nm, "_bp_accepts"}, idx, DEPTH * BPW);
                chk({nm, "_bp_ready"}, pix_ready, 0);
                chk({nm, "_bp_wvalid"}, word_valid, 1);
            end
            if (done_cnt > d0 && post < 0) post = cyc;
            if (post >= 0 && cyc >= post + 3) break;
            n++;
        end
        chk({nm, "_done_pulses"}, done_cnt - d0, 1);
        chk({nm, "_accepted"}, idx, FB);
        chk({nm, "_extra"}, extra, 0);
        chk({nm, "_done_after_pop"}, done_cyc, last_pop_cyc + 1);
        chk({nm, "_idle_busy"}, busy, 0);
        chk({nm, "_byte_count"}, byte_count, FB);
        chk({nm, "_nwords"}, got_w.size(), NW);
        nchk = (got_w.size() < NW) ? got_w.size() : NW;
        for (int w = 0; w < nchk; w++) begin
            chk({nm, "_word"}, got_w[w], exp_word(w));
            chk({nm, "_last"}, got_l[w], (w == NW - 1));
        end
        if (!gaps && hold == 0) chk({nm, "_latency"}, first_pop_cyc, first_acc_cyc + BPW);
    endtask

    initial begin
        int acc5;

        // Reset values
        rst_n = 1'b0;
        tick(1'b0, '0, 1'b0, 1'b0);
        chk("rst_pix_ready", pix_ready, 0);
        chk("rst_word_valid", word_valid, 0);
        chk("rst_word_last", word_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;

        // Bytes offered in IDLE without start are not consumed
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'h55, 1'b1, 1'b0);
            chk("idle_pix_ready", pix_ready, 0);
            chk("idle_accept", acc_f, 0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        chk("idle_byte_count", byte_count, 0);
        chk("idle_busy", busy, 0);

        // Directed frame 0x01..0x0A, no gaps
        for (int i = 0; i < FB; i++) fr[i] = PW'(i + 1);
        run_frame(1'b0, 0, 1'b0, "dir");
        if (got_w.size() == NW) begin
            chk("dir_w0_const", got_w[0], 32'h04030201);
            chk("dir_w1_const", got_w[1], 32'h08070605);
            chk("dir_w2_const", got_w[2], 32'h00000A09);
        end

        // Backpressure with start pulses during capture and drain
        for (int i = 0; i < FB; i++) fr[i] = PW'($urandom);
        run_frame(1'b0, 12, 1'b1, "bp");

        // Reset after 5 of 10 bytes
        for (int i = 0; i < FB; i++) fr[i] = PW'(8'hA0 + i);
        acc5 = done_cnt;
        tick(1'b0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) tick(1'b1, fr[i], 1'b1, 1'b0);
        chk("mid_byte_count", byte_count, 4);
        @(negedge clk);
        rst_n = 1'b0;
        pix_valid = 1'b0;
        start = 1'b0;
        #1;
        chk("mid_rst_pix_ready", pix_ready, 0);
        chk("mid_rst_word_valid", word_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_byte_count", byte_count, 0);
        chk("mid_rst_frame_done", frame_done, 0);
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) tick(1'b0, '0, 1'b1, 1'b0);
        chk("mid_no_done", done_cnt - acc5, 0);
        chk("mid_no_words", word_valid, 0);
        run_frame(1'b0, 0, 1'b0, "post_rst");

        // Random data with random valid / ready gaps
        for (int f = 0; f < 150; f++) begin
            for (int i = 0; i < FB; i++) fr[i] = PW'($urandom);
            run_frame(1'b1, 0, 1'b0, "rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/frame_word_packer.md
Name: frame_word_packer

Overview:
Synthesizable successor to the display adapter's frame image writer. It captures one frame of pixel bytes through a valid/ready handshake and packs them little-endian into host words. Packed words pass through an internal FIFO to a word-stream port that feeds the frame-store or host writer. Frame length, word width and buffer depth are parameters; the end of frame is marked by word_last and a frame_done pulse.

Parameters:
PIX_W, 8, bits per pixel byte lane
BYTES_PER_WORD, 4, lanes per output word (>=1); word width = PIX_W*BYTES_PER_WORD
FRAME_BYTES, 30000, pixel bytes per frame (>=1)
FIFO_DEPTH, 16, output word FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin frame capture; sampled only in IDLE
pix_data  in  PIX_W  pixel byte
pix_valid  in  1  pix_data valid
pix_ready  out  1  block accepts pix_data this cycle
word_data  out  PIX_W*BYTES_PER_WORD  packed word; lane 0 = first byte, in the LSBs
word_valid  out  1  word_data valid (FIFO not empty)
word_ready  in  1  downstream accepts word
word_last  out  1  qualifies word_data as the final word of the frame
frame_done  out  1  one-cycle pulse after the last word is accepted
busy  out  1  high in any state other than IDLE
byte_count  out  clog2(FRAME_BYTES+1)  bytes accepted in the current frame

Behaviour:
- Reset (async, rst_n=0): state IDLE, FIFO empty, lane=0, pack register=0, byte_count=0. All outputs are 0: pix_ready, word_valid, word_last, frame_done, busy.
- States: IDLE, CAPTURE, DRAIN, DONE.
- IDLE -> CAPTURE when start=1. byte_count, lane and the pack register clear on the transition. start is ignored in all other states.
- CAPTURE: pix_ready = !fifo_full. A byte is accepted when pix_valid && pix_ready.
- On each accept, the byte is written to lane `lane` of the pack register, byte_count increments, and lane increments.
- A word is pushed to the FIFO in the same cycle as the accept that fills lane BYTES_PER_WORD-1. lane wraps to 0 and the pack register clears.
- Final accepted byte (byte_count reaches FRAME_BYTES): the word is pushed in that cycle even if partial. Unfilled upper lanes are 0. The entry is tagged last, and the state goes to DRAIN.
- pix_ready is 0 outside CAPTURE. A byte offered in DRAIN, DONE or IDLE is not consumed.
- FIFO: registered storage. word_valid rises no earlier than the cycle after the push, so minimum latency from the completing byte to word_valid is 1 cycle.
- A pop occurs on word_valid && word_ready. A simultaneous push and pop when full is impossible because pix_ready is 0 when full. A simultaneous push and pop in any other condition keeps the count unchanged.
- word_last = word_valid && head entry tagged last.
- DRAIN -> DONE on the cycle the last-tagged word is popped.
- DONE: frame_done=1 for exactly one cycle, then the state goes to IDLE. busy drops in IDLE.
- byte_count holds its final value (FRAME_BYTES) in IDLE until the next start.
- Reset mid-frame discards the FIFO contents and the partial word; there is no frame_done.
- FRAME_BYTES a multiple of BYTES_PER_WORD: there is no padding and the last word is full.
- BYTES_PER_WORD=1: every accept pushes one word.
- Word count per frame = ceil(FRAME_BYTES/BYTES_PER_WORD).

Test Plan:
- FRAME_BYTES=10, BPW=4, PIX_W=8, word_ready=1. start, then bytes 0x01..0x0A back-to-back -> words 0x04030201, 0x08070605, 0x00000A09. word_last on the third word only, frame_done one cycle after its pop, busy low afterwards, byte_count=10.
- Same config with FRAME_BYTES=8 -> exactly 2 words, no padding, word_last on 0x08070605.
- Backpressure: FIFO_DEPTH=2, BPW=1, word_ready=0 -> pix_ready drops after 2 accepts. Releasing word_ready resumes the flow, and the byte order is preserved in the output.
- start pulsed during CAPTURE and DRAIN -> ignored, with no change to byte_count or state. pix_valid held in IDLE -> pix_ready=0 and nothing is accepted.
- Assert rst_n=0 after 5 of 10 bytes -> all outputs 0 immediately and no frame_done. A new start afterwards produces a correct full frame.
- Random pix_valid / word_ready gaps over FRAME_BYTES=30000 -> the output word stream matches the reference packing and there is exactly one frame_done.
